// File: rtl/mcp3x08_scan.sv
// SPI scanner for MCP3008/MCP3208: round-robin channel conversion, one tagged sample per frame.
// Optional null-bit check is built when MCP_NULLCHK_EN is defined.
module mcp3x08_scan #(
    parameter int CHANNELS    = 8,
    parameter int ADC_BITS    = 10,
    parameter int SCLK_DIV    = 25,
    parameter int CS_HIGH_CYC = 50,
    parameter bit SGL         = 1'b1
) (
    input  logic                CLK50,
    input  logic                reset,
    input  logic                enable,
    input  logic                SPI_IN,
    output logic                SPI_OUT,
    output logic                SCLK,
    output logic                CS_n,
    output logic [ADC_BITS-1:0] sample_data,
    output logic [2:0]          sample_chan,
    output logic                sample_valid,
    output logic                frame_err
);

    localparam int CNT_MAX = (SCLK_DIV > CS_HIGH_CYC) ? SCLK_DIV : CS_HIGH_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    // Only the bits that are ever reported are kept from the MISO stream.
`ifdef MCP_NULLCHK_EN
    localparam int SH_W = ADC_BITS + 1;
`else
    localparam int SH_W = ADC_BITS;
`endif
    localparam logic [CW-1:0] DIV_LAST  = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(CS_HIGH_CYC - 1);
    localparam logic [2:0]    CH_LAST   = 3'(CHANNELS - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4:0]          bit_q, bit_d;
    logic                hi_q, hi_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [2:0]          fch_q, fch_d;
    logic [SH_W-1:0]     sh_q, sh_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic [ADC_BITS-1:0] sdat_q, sdat_d;
    logic [2:0]          schan_q, schan_d;
    logic                valid_q, valid_d;
`ifdef MCP_NULLCHK_EN
    logic                ferr_q, ferr_d;
`endif

    function automatic logic mosi_bit(input logic [4:0] k, input logic [2:0] ch);
        logic b;
        b = 1'b0;
        if (k == 5'(17 - ADC_BITS))      b = 1'b1;
        else if (k == 5'(18 - ADC_BITS)) b = SGL;
        else if (k == 5'(19 - ADC_BITS)) b = ch[2];
        else if (k == 5'(20 - ADC_BITS)) b = ch[1];
        else if (k == 5'(21 - ADC_BITS)) b = ch[0];
        return b;
    endfunction

    // Pin values are computed from the current state and registered, so every
    // pin lags the state by one cycle and is glitch-free.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        hi_d    = hi_q;
        ptr_d   = ptr_q;
        fch_d   = fch_q;
        sh_d    = sh_q;
        sdat_d  = sdat_q;
        schan_d = schan_q;
        valid_d = 1'b0;
`ifdef MCP_NULLCHK_EN
        ferr_d  = 1'b0;
`endif
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    fch_d   = ptr_q;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cs_n_d = 1'b0;
                mosi_d = mosi_bit(5'd0, fch_q);
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    bit_d   = 5'd0;
                    hi_d    = 1'b1;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                cs_n_d = 1'b0;
                sclk_d = hi_q;
                // Low half already presents the next bit (changes with the falling edge).
                mosi_d = mosi_bit(hi_q ? bit_q : bit_q + 5'd1, fch_q);
                if (hi_q && cnt_q == '0)
                    sh_d = {sh_q[SH_W-2:0], SPI_IN};
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (hi_q) begin
                        hi_d = 1'b0;
                    end else if (bit_q == 5'd23) begin
                        state_d = HOLD;
                    end else begin
                        hi_d  = 1'b1;
                        bit_d = bit_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    sdat_d  = sh_q[ADC_BITS-1:0];
                    schan_d = fch_q;
                    valid_d = 1'b1;
`ifdef MCP_NULLCHK_EN
                    ferr_d  = sh_q[ADC_BITS];
`endif
                    ptr_d   = (ptr_q == CH_LAST) ? 3'd0 : ptr_q + 3'd1;
                end
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (enable) begin
                        fch_d   = ptr_d;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            hi_q    <= 1'b0;
            ptr_q   <= '0;
            fch_q   <= '0;
            sh_q    <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            sdat_q  <= '0;
            schan_q <= '0;
            valid_q <= 1'b0;
`ifdef MCP_NULLCHK_EN
            ferr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            hi_q    <= hi_d;
            ptr_q   <= ptr_d;
            fch_q   <= fch_d;
            sh_q    <= sh_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            sdat_q  <= sdat_d;
            schan_q <= schan_d;
            valid_q <= valid_d;
`ifdef MCP_NULLCHK_EN
            ferr_q  <= ferr_d;
`endif
        end
    end

    assign SPI_OUT      = mosi_q;
    assign SCLK         = sclk_q;
    assign CS_n         = cs_n_q;
    assign sample_data  = sdat_q;
    assign sample_chan  = schan_q;
    assign sample_valid = valid_q;
`ifdef MCP_NULLCHK_EN
    assign frame_err    = ferr_q;
`else
    assign frame_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mcp3x08_scan.sv
// Bench for mcp3x08_scan: three configurations, each driven by a behavioural ADC model.
module tb_mcp3x08_scan;

    localparam int NB  [3] = '{10, 12, 12};
    localparam int NC  [3] = '{8, 3, 8};
    localparam int DV  [3] = '{25, 2, 2};
    localparam int CSH [3] = '{50, 3, 3};
    localparam bit SG  [3] = '{1'b1, 1'b0, 1'b0};
`ifdef MCP_NULLCHK_EN
    localparam bit NULLCHK = 1'b1;
`else
    localparam bit NULLCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] en = '0;
    wire  [2:0] cs_n, sclk, mosi, valid, ferr;
    wire  [2:0][2:0]  schan;
    wire  [2:0][11:0] sdat;
    wire  [2:0][23:0] mcap;
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] mdata(input int gi, input logic [2:0] c);
        if (gi == 0) return 12'h2A5;
        if (gi == 1) return (c == 3'd0) ? 12'hABC : (c == 3'd1) ? 12'h123 : 12'hFFF;
        return {c, c, c, c};
    endfunction

    function automatic logic bitval(input int gi, input int k, input logic [2:0] c);
        logic [11:0] d;
        int b;
        b = NB[gi];
        d = mdata(gi, c);
        if (k == 23 - b) return (gi == 0 && c == 3'd2);
        if (k >= 24 - b && k <= 23) return d[23-k];
        return 1'b0;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int B = NB[g];
        logic [B-1:0] d;
        logic miso_l = 1'b0;
        logic [23:0] cap_l = '0;
        logic [2:0] mc_l = '0;
        int ridx = 0;
        logic pcs = 1'b1, psc = 1'b0;

        mcp3x08_scan #(.CHANNELS(NC[g]), .ADC_BITS(B), .SCLK_DIV(DV[g]),
                       .CS_HIGH_CYC(CSH[g]), .SGL(SG[g])) u_dut (
            .CLK50(clk), .reset(rst), .enable(en[g]), .SPI_IN(miso_l),
            .SPI_OUT(mosi[g]), .SCLK(sclk[g]), .CS_n(cs_n[g]),
            .sample_data(d), .sample_chan(schan[g]),
            .sample_valid(valid[g]), .frame_err(ferr[g]));

        assign sdat[g] = 12'(d);
        assign mcap[g] = cap_l;

        // ADC model: latches MOSI on SCLK rise, presents the next MISO bit on SCLK fall.
        always @(negedge clk) begin
            if (pcs && !cs_n[g]) begin
                ridx   <= 0;
                cap_l  <= '0;
                miso_l <= 1'b0;
            end else if (!cs_n[g] && !psc && sclk[g]) begin
                cap_l <= {cap_l[22:0], mosi[g]};
                ridx  <= ridx + 1;
                if (ridx == 19 - B) mc_l[2] <= mosi[g];
                if (ridx == 20 - B) mc_l[1] <= mosi[g];
                if (ridx == 21 - B) mc_l[0] <= mosi[g];
            end else if (!cs_n[g] && psc && !sclk[g]) begin
                miso_l <= bitval(g, ridx, mc_l);
            end
            pcs <= cs_n[g];
            psc <= sclk[g];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_valid(input int g, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (valid[g]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rise(input int g, input int n, output bit ok);
        int rc;
        logic p;
        rc = 0;
        p = sclk[g];
        for (int t = 0; t < 5000 && rc < n; t++) begin
            @(negedge clk);
            if (!p && sclk[g]) rc++;
            p = sclk[g];
        end
        ok = (rc == n);
    endtask

    typedef struct {
        int          g;
        logic [2:0]  ch;
        logic [11:0] dat;
        logic        fe;
        logic        chkm;
        logic [23:0] mo;
        int          gap;
    } vec_t;

    vec_t vt [19];

    initial begin
        bit ok;
        int last;
        int bad;
        logic [11:0] d1 [4];
        logic [11:0] d2 [6];
        d1 = '{12'hABC, 12'h123, 12'hFFF, 12'hABC};
        d2 = '{12'h000, 12'h249, 12'h492, 12'h6DB, 12'h924, 12'hB6D};
        for (int i = 0; i < 9; i++)
            vt[i] = '{0, 3'(i % 8), 12'h2A5, NULLCHK && (i % 8 == 2), 1'b0, 24'h0, (i == 0) ? 0 : 1275};
        vt[0].chkm = 1'b1; vt[0].mo = 24'h018000;
        vt[5].chkm = 1'b1; vt[5].mo = 24'h01D000;
        vt[7].chkm = 1'b1; vt[7].mo = 24'h01F000;
        for (int j = 0; j < 4; j++)
            vt[9+j] = '{1, 3'(j % 3), d1[j], 1'b0, 1'b0, 24'h0, (j == 0) ? 0 : 101};
        for (int j = 0; j < 6; j++)
            vt[13+j] = '{2, 3'(j), d2[j], 1'b0, 1'b0, 24'h0, (j == 0) ? 0 : 101};
        vt[13].chkm = 1'b1; vt[13].mo = 24'h040000;
        vt[16].chkm = 1'b1; vt[16].mo = 24'h04C000;
        vt[18].chkm = 1'b1; vt[18].mo = 24'h054000;

        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_cs_n%0d", g), cs_n[g], 1);
            chk($sformatf("rst_sclk%0d", g), sclk[g], 0);
            chk($sformatf("rst_mosi%0d", g), mosi[g], 0);
            chk($sformatf("rst_valid%0d", g), valid[g], 0);
            chk($sformatf("rst_data%0d", g), sdat[g], 0);
            chk($sformatf("rst_chan%0d", g), schan[g], 0);
            chk($sformatf("rst_ferr%0d", g), ferr[g], 0);
        end

        last = 0;
        for (int i = 0; i < 19; i++) begin
            if (i == 0 || vt[i].g != vt[i-1].g) begin
                en = '0;
                apply_reset();
                en[vt[i].g] = 1'b1;
            end
            wait_valid(vt[i].g, ok);
            chk($sformatf("v%0d_timeout", i), ok, 1);
            if (!ok) continue;
            chk($sformatf("v%0d_chan", i), schan[vt[i].g], vt[i].ch);
            chk($sformatf("v%0d_data", i), sdat[vt[i].g], vt[i].dat);
            chk($sformatf("v%0d_ferr", i), ferr[vt[i].g], vt[i].fe);
            chk($sformatf("v%0d_cs_hi", i), cs_n[vt[i].g], 1);
            if (vt[i].chkm) chk($sformatf("v%0d_mosi", i), mcap[vt[i].g], vt[i].mo);
            if (vt[i].gap != 0) chk($sformatf("v%0d_gap", i), cyc - last, vt[i].gap);
            last = cyc;
            @(negedge clk);
            chk($sformatf("v%0d_width", i), valid[vt[i].g], 0);
        end

        // Enable response and CS_n-to-SCLK delay on the fast 12-bit instance.
        en = '0;
        apply_reset();
        en[1] = 1'b1;
        @(negedge clk); chk("en_cs_lag1", cs_n[1], 1);
        @(negedge clk); chk("en_cs_lag2", cs_n[1], 0);
        chk("setup_sclk0", sclk[1], 0);
        @(negedge clk); chk("setup_sclk1", sclk[1], 0);
        @(negedge clk); chk("first_rise", sclk[1], 1);

        // Drop enable at bit 10: frame completes, then the block stays idle.
        wait_rise(1, 10, ok);
        chk("drop_to", ok, 1);
        en[1] = 1'b0;
        wait_valid(1, ok);
        chk("drop_valid_to", ok, 1);
        chk("drop_chan", schan[1], 0);
        chk("drop_data", sdat[1], 12'hABC);
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (!cs_n[1] || valid[1]) bad++;
        end
        chk("idle_after_drop", bad, 0);
        en[1] = 1'b1;
        wait_valid(1, ok);
        chk("resume_to", ok, 1);
        chk("resume_chan", schan[1], 1);
        chk("resume_data", sdat[1], 12'h123);

        // Reset at bit 15 of the channel-2 frame.
        wait_rise(1, 16, ok);
        chk("rst15_to", ok, 1);
        rst = 1'b1;
        #1;
        chk("rst15_cs_n", cs_n[1], 1);
        chk("rst15_sclk", sclk[1], 0);
        chk("rst15_mosi", mosi[1], 0);
        chk("rst15_data", sdat[1], 0);
        chk("rst15_chan", schan[1], 0);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (valid[1]) bad++;
        end
        chk("rst15_novalid", bad, 0);
        rst = 1'b0;
        wait_valid(1, ok);
        chk("postrst_to", ok, 1);
        chk("postrst_chan", schan[1], 0);
        chk("postrst_data", sdat[1], 12'hABC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(20 * 90000);
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
